// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU.
// Captures decoded ID fields, bypasses a same-cycle WB write into the
// captured operands, forwards MEM/WB results onto the ALU operands,
// detects load-use hazards and honours a downstream hold.
// Optional feature macro: IDEX_SHAMT_EN (immediate shift-amount path).
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          flush,
  input  logic          idValid,
  input  logic [DW-1:0] idPC,
  input  logic [DW-1:0] idRsData,
  input  logic [DW-1:0] idRtData,
  input  logic [DW-1:0] idImm,
  input  logic [RW-1:0] idRs,
  input  logic [RW-1:0] idRt,
  input  logic [RW-1:0] idWriteReg,
  input  logic          idUsesRt,
  input  logic          idRegWrite,
  input  logic          idMemToReg,
  input  logic          idMemWrite,
  input  logic          idAluSrc,
  input  logic [3:0]    idAluCtrl,
`ifdef IDEX_SHAMT_EN
  input  logic          idShiftSel,
`endif
  input  logic          memRegWrite,
  input  logic [RW-1:0] memWriteReg,
  input  logic [DW-1:0] memResult,
  input  logic          wbRegWrite,
  input  logic [RW-1:0] wbWriteReg,
  input  logic [DW-1:0] wbResult,
  output logic [DW-1:0] reg1,
  output logic [DW-1:0] reg2,
  output logic [3:0]    aluCtrl,
  output logic [DW-1:0] exRtData,
  output logic [DW-1:0] exPC,
  output logic [RW-1:0] exWriteReg,
  output logic          exValid,
  output logic          exRegWrite,
  output logic          exMemToReg,
  output logic          exMemWrite,
  output logic          stallReq
);

  logic          vld_p1;
  logic          reg_write_p1;
  logic          mem_to_reg_p1;
  logic          mem_write_p1;
  logic          alu_src_p1;
  logic [3:0]    alu_ctrl_p1;
  logic [DW-1:0] pc_p1;
  logic [DW-1:0] rs_data_p1;
  logic [DW-1:0] rt_data_p1;
  logic [DW-1:0] imm_p1;
  logic [RW-1:0] rs_p1;
  logic [RW-1:0] rt_p1;
  logic [RW-1:0] write_reg_p1;
  logic          shift_sel_p1;
  logic          shift_sel_id;

  logic          use_rs;
  logic          use_rt;
  logic          hazard;
  logic [DW-1:0] cap_rs;
  logic [DW-1:0] cap_rt;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  // True when the WB stage is writing a non-zero register matching idx.
  function automatic logic wb_hit(input logic [RW-1:0] idx, input logic we,
                                  input logic [RW-1:0] wreg);
    return we && (wreg == idx) && (idx != '0);
  endfunction

  // Operand forwarding: MEM beats WB beats the stored value; r0 and bubbles read 0.
  function automatic logic [DW-1:0] forward(
    input logic          vld,
    input logic [RW-1:0] idx,
    input logic [DW-1:0] stored,
    input logic          m_we,
    input logic [RW-1:0] m_reg,
    input logic [DW-1:0] m_res,
    input logic          w_we,
    input logic [RW-1:0] w_reg,
    input logic [DW-1:0] w_res
  );
    if (!vld || idx == '0)               return '0;
    else if (m_we && m_reg == idx)       return m_res;
    else if (w_we && w_reg == idx)       return w_res;
    else                                 return stored;
  endfunction

`ifdef IDEX_SHAMT_EN
  assign shift_sel_id = idShiftSel;
`else
  assign shift_sel_id = 1'b0;
`endif

  // ID-side operand capture with same-cycle WB bypass, plus load-use detection.
  always_comb begin
    cap_rs = wb_hit(idRs, wbRegWrite, wbWriteReg) ? wbResult : idRsData;
    cap_rt = wb_hit(idRt, wbRegWrite, wbWriteReg) ? wbResult : idRtData;
    use_rs = !shift_sel_id;
    use_rt = idUsesRt || shift_sel_id;
    hazard = vld_p1 && mem_to_reg_p1 && (write_reg_p1 != '0) && idValid &&
             ((use_rs && write_reg_p1 == idRs) || (use_rt && write_reg_p1 == idRt));
    stallReq = hazard && !hold;
  end

  // Stage register: reset > hold (with WB refresh) > bubble > capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1        <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      mem_write_p1  <= 1'b0;
      alu_src_p1    <= 1'b0;
      alu_ctrl_p1   <= '0;
      pc_p1         <= '0;
      rs_data_p1    <= '0;
      rt_data_p1    <= '0;
      imm_p1        <= '0;
      rs_p1         <= '0;
      rt_p1         <= '0;
      write_reg_p1  <= '0;
      shift_sel_p1  <= 1'b0;
    end else if (hold) begin
      if (wb_hit(rs_p1, wbRegWrite, wbWriteReg)) rs_data_p1 <= wbResult;
      if (wb_hit(rt_p1, wbRegWrite, wbWriteReg)) rt_data_p1 <= wbResult;
    end else if (flush || stallReq) begin
      vld_p1        <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      mem_write_p1  <= 1'b0;
      alu_src_p1    <= 1'b0;
      alu_ctrl_p1   <= '0;
      pc_p1         <= '0;
      rs_data_p1    <= '0;
      rt_data_p1    <= '0;
      imm_p1        <= '0;
      rs_p1         <= '0;
      rt_p1         <= '0;
      write_reg_p1  <= '0;
      shift_sel_p1  <= 1'b0;
    end else begin
      vld_p1        <= idValid;
      reg_write_p1  <= idRegWrite;
      mem_to_reg_p1 <= idMemToReg;
      mem_write_p1  <= idMemWrite;
      alu_src_p1    <= idAluSrc;
      alu_ctrl_p1   <= idAluCtrl;
      pc_p1         <= idPC;
      rs_data_p1    <= cap_rs;
      rt_data_p1    <= cap_rt;
      imm_p1        <= idImm;
      rs_p1         <= idRs;
      rt_p1         <= idRt;
      write_reg_p1  <= idWriteReg;
      shift_sel_p1  <= shift_sel_id;
    end
  end

  // EX side: forwarded operands and ALU operand selection.
  always_comb begin
    fwd_rs = forward(vld_p1, rs_p1, rs_data_p1, memRegWrite, memWriteReg, memResult,
                     wbRegWrite, wbWriteReg, wbResult);
    fwd_rt = forward(vld_p1, rt_p1, rt_data_p1, memRegWrite, memWriteReg, memResult,
                     wbRegWrite, wbWriteReg, wbResult);
    if (shift_sel_p1) begin
      reg1 = fwd_rt;
      reg2 = {{(DW-5){1'b0}}, imm_p1[10:6]};
    end else begin
      reg1 = fwd_rs;
      reg2 = alu_src_p1 ? imm_p1 : fwd_rt;
    end
    exRtData = fwd_rt;
  end

  assign aluCtrl    = alu_ctrl_p1;
  assign exPC       = pc_p1;
  assign exWriteReg = write_reg_p1;
  assign exValid    = vld_p1;
  assign exRegWrite = reg_write_p1;
  assign exMemToReg = mem_to_reg_p1;
  assign exMemWrite = mem_write_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// instruction sitting in EX.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold, flush, idValid;
  logic [31:0] idPC, idRsData, idRtData, idImm;
  logic [4:0]  idRs, idRt, idWriteReg;
  logic        idUsesRt, idRegWrite, idMemToReg, idMemWrite, idAluSrc;
  logic [3:0]  idAluCtrl;
  logic        idShiftSel;
  logic        memRegWrite, wbRegWrite;
  logic [4:0]  memWriteReg, wbWriteReg;
  logic [31:0] memResult, wbResult;
  logic [31:0] reg1, reg2, exRtData, exPC;
  logic [3:0]  aluCtrl;
  logic [4:0]  exWriteReg;
  logic        exValid, exRegWrite, exMemToReg, exMemWrite, stallReq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .idValid(idValid), .idPC(idPC), .idRsData(idRsData), .idRtData(idRtData),
    .idImm(idImm), .idRs(idRs), .idRt(idRt), .idWriteReg(idWriteReg),
    .idUsesRt(idUsesRt), .idRegWrite(idRegWrite), .idMemToReg(idMemToReg),
    .idMemWrite(idMemWrite), .idAluSrc(idAluSrc), .idAluCtrl(idAluCtrl),
`ifdef IDEX_SHAMT_EN
    .idShiftSel(idShiftSel),
`endif
    .memRegWrite(memRegWrite), .memWriteReg(memWriteReg), .memResult(memResult),
    .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg), .wbResult(wbResult),
    .reg1(reg1), .reg2(reg2), .aluCtrl(aluCtrl), .exRtData(exRtData),
    .exPC(exPC), .exWriteReg(exWriteReg), .exValid(exValid),
    .exRegWrite(exRegWrite), .exMemToReg(exMemToReg), .exMemWrite(exMemWrite),
    .stallReq(stallReq)
  );

  // Model of the instruction currently in EX.
  typedef struct {
    logic        v;
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, wr;
    logic        rw, m2r, mw, as, sh;
    logic [3:0]  op;
  } ex_t;

  ex_t m;

  function automatic ex_t bubble();
    ex_t b;
    b = '{v:1'b0, pc:32'd0, rsd:32'd0, rtd:32'd0, imm:32'd0, rs:5'd0, rt:5'd0,
          wr:5'd0, rw:1'b0, m2r:1'b0, mw:1'b0, as:1'b0, sh:1'b0, op:4'd0};
    return b;
  endfunction

  function automatic logic sh_id();
`ifdef IDEX_SHAMT_EN
    return idShiftSel;
`else
    return 1'b0;
`endif
  endfunction

  // Value the ALU should see for a register of the EX instruction.
  function automatic logic [31:0] value_of(input logic [4:0] idx, input logic [31:0] stored);
    if (!m.v || idx == 0) return 32'd0;
    if (memRegWrite && memWriteReg == idx) return memResult;
    if (wbRegWrite && wbWriteReg == idx) return wbResult;
    return stored;
  endfunction

  function automatic logic model_stall();
    logic reads_rs, reads_rt;
    reads_rs = !sh_id();
    reads_rt = idUsesRt || sh_id();
    if (hold || !idValid || !m.v || !m.m2r || m.wr == 0) return 1'b0;
    return (reads_rs && m.wr == idRs) || (reads_rt && m.wr == idRt);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] frs, frt, e1, e2;
    frs = value_of(m.rs, m.rsd);
    frt = value_of(m.rt, m.rtd);
    e1 = m.sh ? frt : frs;
    e2 = m.sh ? {27'd0, m.imm[10:6]} : (m.as ? m.imm : frt);
    check({tag, ".reg1"}, reg1, e1);
    check({tag, ".reg2"}, reg2, e2);
    check({tag, ".rtdata"}, exRtData, frt);
    check({tag, ".aluctrl"}, {28'd0, aluCtrl}, {28'd0, m.op});
    check({tag, ".pc"}, exPC, m.pc);
    check({tag, ".wr"}, {27'd0, exWriteReg}, {27'd0, m.wr});
    check({tag, ".ctl"}, {28'd0, exValid, exRegWrite, exMemToReg, exMemWrite},
          {28'd0, m.v, m.rw, m.m2r, m.mw});
    check({tag, ".stall"}, {31'd0, stallReq}, {31'd0, model_stall()});
  endtask

  // Advance one clock, updating the model from the pre-edge inputs.
  task automatic tick();
    ex_t n;
    logic st;
    st = model_stall();
    n = m;
    if (hold) begin
      if (wbRegWrite && wbWriteReg == m.rs && m.rs != 0) n.rsd = wbResult;
      if (wbRegWrite && wbWriteReg == m.rt && m.rt != 0) n.rtd = wbResult;
    end else if (flush || st) begin
      n = bubble();
    end else begin
      n.v = idValid; n.pc = idPC; n.imm = idImm;
      n.rs = idRs; n.rt = idRt; n.wr = idWriteReg;
      n.rw = idRegWrite; n.m2r = idMemToReg; n.mw = idMemWrite;
      n.as = idAluSrc; n.op = idAluCtrl; n.sh = sh_id();
      n.rsd = (wbRegWrite && wbWriteReg == idRs && idRs != 0) ? wbResult : idRsData;
      n.rtd = (wbRegWrite && wbWriteReg == idRt && idRt != 0) ? wbResult : idRtData;
    end
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] wr, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [31:0] imm, input logic urt,
                        input logic rw, input logic m2r, input logic mw, input logic as,
                        input logic [3:0] op);
    idValid = v; idPC = pc; idRs = rs; idRt = rt; idWriteReg = wr;
    idRsData = rsd; idRtData = rtd; idImm = imm; idUsesRt = urt;
    idRegWrite = rw; idMemToReg = m2r; idMemWrite = mw; idAluSrc = as; idAluCtrl = op;
  endtask

  task automatic clr_fwd();
    memRegWrite = 0; memWriteReg = 0; memResult = 0;
    wbRegWrite = 0; wbWriteReg = 0; wbResult = 0;
  endtask

  initial begin
    logic [3:0] ops [4];
    ops[0] = 4'b0010; ops[1] = 4'b0110; ops[2] = 4'b0001; ops[3] = 4'b0100;
    rst_n = 0; hold = 0; flush = 0; idShiftSel = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    clr_fwd();
    m = bubble();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check_all("reset");
    check("reset.valid", {31'd0, exValid}, 32'd0);

    // Asynchronous reset with a valid instruction loaded.
    set_id(1, 32'h40, 5'd3, 5'd4, 5'd5, 32'h5, 32'h6, 0, 1, 1, 0, 0, 0, 4'b0010);
    tick();
    check("preload.reg1", reg1, 32'h5);
    idValid = 0;
    #2 rst_n = 0;
    m = bubble();
    #1;
    check("arst.valid", {31'd0, exValid}, 32'd0);
    check("arst.reg1", reg1, 32'd0);
    check("arst.aluctrl", {28'd0, aluCtrl}, 32'd0);
    #1 rst_n = 1;
    tick();
    check("after_rst.valid", {31'd0, exValid}, 32'd0);

    // MEM forwarding beats WB.
    set_id(1, 32'h100, 5'd3, 5'd4, 5'd5, 32'h5, 32'h6, 0, 1, 1, 0, 0, 0, 4'b0010);
    tick();
    idValid = 0;
    memRegWrite = 1; memWriteReg = 3; memResult = 32'h10;
    wbRegWrite = 1; wbWriteReg = 3; wbResult = 32'h20;
    #1;
    check("memprio.reg1", reg1, 32'h10);
    check("memprio.reg2", reg2, 32'h6);
    check_all("memprio");
    clr_fwd();

    // Register 0 is never forwarded.
    set_id(1, 32'h104, 5'd0, 5'd4, 5'd5, 32'h1234, 32'h6, 0, 1, 1, 0, 0, 0, 4'b0001);
    tick();
    idValid = 0;
    memRegWrite = 1; memWriteReg = 0; memResult = 32'hFFFF;
    wbRegWrite = 1; wbWriteReg = 0; wbResult = 32'hEEEE;
    #1;
    check("r0.reg1", reg1, 32'd0);
    clr_fwd();

    // Load-use hazard: one bubble, then forward the load result.
    set_id(1, 32'h108, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2, 32'h4, 0, 1, 1, 0, 1, 4'b0010);
    tick();
    set_id(1, 32'h10C, 5'd8, 5'd9, 5'd10, 32'h0, 32'h3, 0, 1, 1, 0, 0, 0, 4'b0010);
    #1;
    check("loaduse.stall", {31'd0, stallReq}, 32'd1);
    tick();
    check("loaduse.bubble", {31'd0, exValid}, 32'd0);
    check("loaduse.nostall", {31'd0, stallReq}, 32'd0);
    tick();
    idValid = 0;
    memRegWrite = 1; memWriteReg = 8; memResult = 32'hCAFE;
    #1;
    check("loaduse.fwd", reg1, 32'hCAFE);
    check_all("loaduse");
    clr_fwd();

    // Hold beats flush; held WB refresh; flush after hold.
    set_id(1, 32'h200, 5'd3, 5'd4, 5'd7, 32'h5, 32'h6, 0, 1, 1, 0, 0, 0, 4'b0110);
    tick();
    set_id(1, 32'h300, 5'd1, 5'd2, 5'd9, 32'h11, 32'h22, 0, 1, 1, 0, 0, 0, 4'b0001);
    hold = 1; flush = 1;
    tick();
    check("hold.pc", exPC, 32'h200);
    check("hold.valid", {31'd0, exValid}, 32'd1);
    check("hold.reg2", reg2, 32'h6);
    wbRegWrite = 1; wbWriteReg = 4; wbResult = 32'h77;
    tick();
    clr_fwd();
    #1;
    check("hold.refresh", reg2, 32'h77);
    check("hold.wr", {27'd0, exWriteReg}, 32'd7);
    hold = 0;
    tick();
    check("flush.valid", {31'd0, exValid}, 32'd0);
    flush = 0;

    // Stall request suppressed while held.
    set_id(1, 32'h400, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2, 0, 0, 1, 1, 0, 1, 4'b0010);
    tick();
    set_id(1, 32'h404, 5'd8, 5'd0, 5'd3, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0010);
    hold = 1;
    #1;
    check("holdstall", {31'd0, stallReq}, 32'd0);
    hold = 0;
    #1;
    check("stall_release", {31'd0, stallReq}, 32'd1);
    flush = 1;
    tick();
    flush = 0;

    // Capture bypass into rt and immediate operand.
    set_id(1, 32'h500, 5'd1, 5'd9, 5'd3, 32'h1, 32'h0, 0, 1, 1, 0, 0, 0, 4'b0010);
    wbRegWrite = 1; wbWriteReg = 9; wbResult = 32'hABCD;
    tick();
    clr_fwd();
    idValid = 0;
    #1;
    check("bypass.rtdata", exRtData, 32'hABCD);
    set_id(1, 32'h504, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'hFFFFFFF0, 0, 1, 0, 0, 1, 4'b0010);
    tick();
    idValid = 0;
    #1;
    check("imm.reg2", reg2, 32'hFFFFFFF0);

`ifdef IDEX_SHAMT_EN
    set_id(1, 32'h508, 5'd3, 5'd4, 5'd5, 32'h5, 32'h99, 32'd4 << 6, 1, 1, 0, 0, 1, 4'b0100);
    idShiftSel = 1;
    tick();
    idShiftSel = 0; idValid = 0;
    #1;
    check("shamt.reg2", reg2, 32'd4);
    check("shamt.reg1", reg1, 32'h99);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      hold = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      set_id($urandom_range(0, 1), $urandom, 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), ops[$urandom_range(0, 3)]);
`ifdef IDEX_SHAMT_EN
      idShiftSel = ($urandom_range(0, 3) == 0);
`endif
      memRegWrite = $urandom_range(0, 1); memWriteReg = 5'($urandom_range(0, 7));
      memResult = $urandom;
      wbRegWrite = $urandom_range(0, 1); wbWriteReg = 5'($urandom_range(0, 7));
      wbResult = $urandom;
      #1;
      check_all("rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the EX-stage ALU.
- Captures decoded ID-stage fields, applies MEM/WB operand forwarding, and drives the ALU's reg1, reg2 and aluCtrl.
- Detects load-use hazards and inserts bubbles.
- Honours a downstream hold (e.g. multi-cycle EX busy).

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- hold  in  1  freeze stage contents (downstream stall).
- flush  in  1  replace next captured instruction with bubble (branch/exception).
- idValid  in  1  ID holds a real instruction.
- idPC  in  DW  instruction PC.
- idRsData, idRtData  in  DW  register-file read data.
- idImm  in  DW  already-extended immediate.
- idRs, idRt, idWriteReg  in  RW  source and destination indices.
- idUsesRt  in  1  instruction reads rt as a register.
- idRegWrite, idMemToReg, idMemWrite, idAluSrc  in  1  control bits.
- idAluCtrl  in  4  ALU op (0010 add, 0110 sub, 0001 or, 0100 shl).
- memRegWrite  in  1  MEM-stage write enable.
- memWriteReg  in  RW  MEM-stage destination.
- memResult  in  DW  MEM-stage result.
- wbRegWrite  in  1  WB-stage write enable.
- wbWriteReg  in  RW  WB-stage destination.
- wbResult  in  DW  WB-stage result.
- reg1, reg2  out  DW  ALU operands.
- aluCtrl  out  4  ALU op.
- exRtData  out  DW  forwarded rt, used as store data.
- exPC  out  DW  registered PC.
- exWriteReg  out  RW  registered destination.
- exValid, exRegWrite, exMemToReg, exMemWrite  out  1  registered control.
- stallReq  out  1  load-use stall request to PC and IF/ID.

Behaviour:
- Reset (rst_n low, asynchronous): all registered fields cleared to 0. Outputs form a bubble: exValid=0, all write/mem enables 0, aluCtrl=0000, reg1=reg2=exRtData=0.
- Per-edge update priority: reset > hold > (flush | stallReq) > load.
  - hold=1: contents frozen. flush and stallReq are ignored that edge; the requester must keep asserting.
  - flush=1 or stallReq=1 (hold=0): load a bubble (all fields 0).
  - Otherwise: capture all id* fields.
- Capture bypass: when loading, if wbRegWrite and wbWriteReg==idRs and idRs!=0, store wbResult instead of idRsData. Same rule for rt.
- Held refresh: while hold=1, a matching WB write (same conditions, against the stored rs/rt indices) updates the stored data. Valid, control and index fields do not change.
- Forwarding (combinational on stored rs/rt indices):
  - MEM match beats WB match, which beats the stored value.
  - A match requires write-enable=1 and index!=0.
  - Register 0 always reads 0.
  - Forwarding is evaluated only when exValid=1; for a bubble, the forwarded operands are 0.
- Operand mapping:
  - reg1 = fwdRs.
  - reg2 = exAluSrc ? exImm : fwdRt.
  - exRtData = fwdRt.
- stallReq (combinational) = exValid & exMemToReg & exWriteReg!=0 & (exWriteReg==idRs | (idUsesRt & exWriteReg==idRt)) & idValid.
  - stallReq is forced to 0 while hold=1.
  - One bubble resolves a load-use hazard; the next cycle forwards from MEM.
- Latency: one cycle from ID capture to EX outputs. Forwarded operands are valid the same cycle as the MEM/WB inputs.

Optional Feature:
- Macro: IDEX_SHAMT_EN.
- Defined:
  - Adds input idShiftSel (1 bit), registered as exShiftSel.
  - When exShiftSel=1: reg1 = fwdRt, reg2 = {27'b0, exImm[10:6]} (sll rd,rt,shamt). idAluSrc is ignored.
  - stallReq treats rt as used and rs as unused.
- Undefined: port absent; only the register-amount shift path (reg1 = rs, reg2 = rt/imm) exists.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with a valid instruction loaded -> outputs zero immediately without waiting for a clock edge; exValid=0 after release until the first load.
- MEM priority: load add rs=3 rt=4 (data 5, 6). Drive memRegWrite=1 memWriteReg=3 memResult=0x10, and wbRegWrite=1 wbWriteReg=3 wbResult=0x20 -> reg1=0x10, reg2=6.
- Register 0 never forwarded: memWriteReg=0, memResult=0xFFFF, rs=0 -> reg1=0.
- Load-use: EX holds lw to r8; ID presents add with rs=8 -> stallReq=1; next edge exValid=0 (bubble); then reg1 = memResult from MEM.
- Hold vs flush: hold=1 and flush=1 together -> contents unchanged. During the hold, wbRegWrite to r4=0x77 updates stored rt -> reg2=0x77. Deassert hold with flush=1 -> bubble.
- Capture bypass and immediate (IDEX_SHAMT_EN variant for the shift case):
  - Load with wbWriteReg=idRt=9, wbResult=0xABCD, idRtData=0 -> exRtData=0xABCD.
  - idAluSrc=1, idImm=0xFFFFFFF0 -> reg2=0xFFFFFFF0.
  - Shift case: idShiftSel=1, idImm[10:6]=4 -> reg2=4, reg1=fwdRt.
